div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- FSM that sequences the N-bit restoring-division datapath: the A/Q shift register plus the external A-minus-divisor subtractor.
- Drives the load, shift, hab_A and set_Q0 strobes of the A/Q register.
- Decides restore vs. commit from the subtractor sign bit.
- Provides a start/busy/done handshake to the surrounding system, plus a divide-by-zero flag.

Parameters:
N, 4, dividend/quotient width in bits; iteration count equals N.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request a division; accepted only in IDLE.
divisor_zero  input  1  high when the divisor operand is 0; sampled with start.
sinal  input  1  sign bit (bit N) of the subtractor output A-M, computed combinationally from the current regA.
load  output  1  load strobe to the A/Q register (A<=0, Q<=dividend).
shift  output  1  shift {A,Q} left by 1.
hab_A  output  1  write subtractor result into A.
set_Q0  output  1  set Q[0]=1.
busy  output  1  operation in progress.
done  output  1  one-cycle completion pulse.
erro  output  1  divide-by-zero flag, valid with done.
count  output  $clog2(N+1)  remaining iterations.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; count=0.
  - Reset mid-operation aborts immediately. Datapath contents are then don't-care.
- Strobes:
  - At most one of load/shift/hab_A/set_Q0 is high in any cycle. The A/Q register has an else-if priority chain, so this is mandatory.
  - All strobes are Moore except hab_A (Mealy on sinal).
- States:
  - IDLE:
    - busy=0.
    - start=1 and divisor_zero=1 -> DONE with erro latched 1; no datapath strobe issued.
    - start=1 and divisor_zero=0 -> LOAD; erro cleared to 0.
    - Otherwise stay.
  - LOAD:
    - load=1, busy=1, count<=N; -> SHIFT.
  - SHIFT:
    - shift=1, busy=1; -> SUB.
  - SUB:
    - busy=1; sinal is evaluated on the post-shift A.
    - sinal=0 (A>=M): hab_A=1 this cycle; -> SETQ.
    - sinal=1 (restore): no strobe, A is unchanged, Q[0] stays 0 from the shift. count<=count-1. If count==1 -> DONE, else -> SHIFT.
  - SETQ:
    - set_Q0=1, busy=1, count<=count-1.
    - count==1 -> DONE, else -> SHIFT.
  - DONE:
    - done=1, busy=0, erro holds its value; -> IDLE unconditionally.
    - start is ignored in this cycle.
- erro persists until the next accepted start.
- start while busy or in DONE is ignored, with no queuing.
- Timing:
  - Let e0 be the edge on which start is accepted. Let K be the number of 1 bits in the resulting quotient.
  - LOAD takes 1 cycle. Each iteration takes 2 cycles if restored, 3 if committed.
  - The DONE state is entered at edge e0+2N+K+1, so done is high during the following cycle.
  - Divide-by-zero: DONE is entered at e0, done is high during the next cycle.
- When done is high: regQ holds the quotient and regA[N-1:0] holds the remainder, with regA[N]=0.
- count:
  - Reads N after LOAD and decrements once per completed iteration.
  - Reads 0 in DONE and keeps that value in IDLE until the next LOAD.
- No count underflow is possible, because exit happens at count==1.

Test Plan:
- Reset during SUB of an active division (rst pulsed low asynchronously, mid-cycle) -> all outputs 0 immediately, state IDLE. A following start runs normally.
- N=4, dividend 13, divisor 3 -> strobe sequence load, shift, -, shift, hab_A, set_Q0, shift, -, shift, -. done at edge e0+10; Q=4, R=1, erro=0.
- N=4, 15/1 -> four committed iterations (K=4). done at edge e0+13; Q=15, R=0. set_Q0 pulsed 4 times, and never in the same cycle as hab_A.
- N=4, 7/8 -> all iterations restore, hab_A never high. done at edge e0+9; Q=0, R=7.
- divisor_zero=1 with start -> no load/shift strobes; done=1 and erro=1 in the cycle after e0. Then 6/2 -> erro cleared, Q=3, R=0.
- start held high through the whole 13/3 run and into DONE -> exactly one operation. A second operation starts only from IDLE, and busy drops in the done cycle.

Source files
------------

// File: rtl/div_ctrl.sv
// Control FSM for an N-bit restoring divider: sequences the A/Q register strobes,
// chooses restore vs. commit from the subtractor sign, and provides start/busy/done.
module div_ctrl #(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     divisor_zero,
  input  logic                     sinal,
  output logic                     load,
  output logic                     shift,
  output logic                     hab_A,
  output logic                     set_Q0,
  output logic                     busy,
  output logic                     done,
  output logic                     erro,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SUB,
    SETQ,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count_nxt;
  logic            erro_nxt;

  // State, iteration counter and error flag; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      erro  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      erro  <= erro_nxt;
    end
  end

  // Only one strobe may be active per state because the A/Q register uses a priority chain.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    erro_nxt  = erro;
    load      = 1'b0;
    shift     = 1'b0;
    hab_A     = 1'b0;
    set_Q0    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (divisor_zero) begin
            erro_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            erro_nxt  = 1'b0;
            state_nxt = LOAD;
          end
        end
      end

      LOAD: begin
        load      = 1'b1;
        busy      = 1'b1;
        count_nxt = CNT_N;
        state_nxt = SHIFT;
      end

      SHIFT: begin
        shift     = 1'b1;
        busy      = 1'b1;
        state_nxt = SUB;
      end

      // A non-negative difference is committed now; a negative one leaves A untouched.
      SUB: begin
        busy = 1'b1;
        if (!sinal) begin
          hab_A     = 1'b1;
          state_nxt = SETQ;
        end else begin
          count_nxt = count - CNT_ONE;
          state_nxt = (count == CNT_ONE) ? DONE : SHIFT;
        end
      end

      SETQ: begin
        set_Q0    = 1'b1;
        busy      = 1'b1;
        count_nxt = count - CNT_ONE;
        state_nxt = (count == CNT_ONE) ? DONE : SHIFT;
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a behavioural A/Q register and subtractor close the loop,
// and quotient, remainder, strobe order and completion timing are checked against hand values.
module tb_div_ctrl;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       divisor_zero;
  logic       sinal;
  logic       load, shift, hab_A, set_Q0, busy, done, erro;
  logic [2:0] count;

  logic [N:0]   rega;
  logic [N-1:0] regq;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N:0]   diff;

  int total = 0;
  int bad   = 0;

  // Results of the most recent run.
  int          cyc;
  int          done_cyc;
  int          n_load, n_shift, n_hab, n_setq, n_overlap;
  logic [63:0] seq;
  logic        erro_at_done, busy_at_done;
  logic [N-1:0] q_at_done;
  logic [N:0]  a_at_done;
  logic [2:0]  count_after_load, count_at_done;
  bit          got_done;

  div_ctrl #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .divisor_zero (divisor_zero),
    .sinal        (sinal),
    .load         (load),
    .shift        (shift),
    .hab_A        (hab_A),
    .set_Q0       (set_Q0),
    .busy         (busy),
    .done         (done),
    .erro         (erro),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign diff  = rega - {1'b0, divisor};
  assign sinal = diff[N];

  // Datapath model with the same else-if priority as the real A/Q register.
  always_ff @(posedge clk) begin
    if (load) begin
      rega <= '0;
      regq <= dividend;
    end else if (shift) begin
      {rega, regq} <= {rega[N-1:0], regq, 1'b0};
    end else if (hab_A) begin
      rega <= diff;
    end else if (set_Q0) begin
      regq[0] <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one division from IDLE (called on a falling edge) and follows it until done.
  task automatic applyStimulus(input logic [N-1:0] dvd, input logic [N-1:0] dvs, input bit hold);
    logic [3:0] code;
    dividend     = dvd;
    divisor      = dvs;
    divisor_zero = (dvs == '0);
    start        = 1'b1;
    cyc = 0; done_cyc = -1; seq = '0; got_done = 0;
    n_load = 0; n_shift = 0; n_hab = 0; n_setq = 0; n_overlap = 0;
    count_after_load = 'x; count_at_done = 'x;
    while (!got_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        start        = 1'b0;
        divisor_zero = 1'b0;
      end
      if (cyc == 2) count_after_load = count;
      if ((int'(load) + int'(shift) + int'(hab_A) + int'(set_Q0)) > 1) n_overlap++;
      n_load  += int'(load);
      n_shift += int'(shift);
      n_hab   += int'(hab_A);
      n_setq  += int'(set_Q0);
      if (done) begin
        got_done      = 1;
        done_cyc      = cyc;
        erro_at_done  = erro;
        busy_at_done  = busy;
        q_at_done     = regq;
        a_at_done     = rega;
        count_at_done = count;
        start         = 1'b0;
        divisor_zero  = 1'b0;
      end else begin
        code = load ? 4'd1 : shift ? 4'd2 : hab_A ? 4'd3 : set_Q0 ? 4'd4 : 4'd0;
        seq  = {seq[59:0], code};
      end
    end
    start        = 1'b0;
    divisor_zero = 1'b0;
    checkOutput("completed_within_budget", 64'(got_done), 64'd1);
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    divisor_zero = 1'b0;
    dividend     = '0;
    divisor      = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {load, shift, hab_A, set_Q0, busy, done, erro, count}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_outputs", {load, shift, hab_A, set_Q0, busy, done, erro, count}, 64'd0);

    // Asynchronous reset landing in the SUB cycle of 13/3.
    $display("[TB] reset during SUB");
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("sub_busy_before_reset", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1 checkOutput("async_reset_outputs", {load, shift, hab_A, set_Q0, busy, done, erro, count}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] 13 / 3");
    applyStimulus(4'd13, 4'd3, 1'b0);
    checkOutput("13_3_done_cycle", 64'(done_cyc), 64'd11);
    checkOutput("13_3_strobe_seq", seq, 64'h1202342020);
    checkOutput("13_3_quotient", 64'(q_at_done), 64'd4);
    checkOutput("13_3_remainder", 64'(a_at_done), 64'd1);
    checkOutput("13_3_erro", 64'(erro_at_done), 64'd0);
    checkOutput("13_3_count_after_load", 64'(count_after_load), 64'd4);
    checkOutput("13_3_count_at_done", 64'(count_at_done), 64'd0);
    @(negedge clk);

    $display("[TB] 15 / 1");
    applyStimulus(4'd15, 4'd1, 1'b0);
    checkOutput("15_1_done_cycle", 64'(done_cyc), 64'd14);
    checkOutput("15_1_strobe_seq", seq, 64'h1234234234234);
    checkOutput("15_1_setq_pulses", 64'(n_setq), 64'd4);
    checkOutput("15_1_overlap", 64'(n_overlap), 64'd0);
    checkOutput("15_1_quotient", 64'(q_at_done), 64'd15);
    checkOutput("15_1_remainder", 64'(a_at_done), 64'd0);
    @(negedge clk);

    $display("[TB] 7 / 8");
    applyStimulus(4'd7, 4'd8, 1'b0);
    checkOutput("7_8_done_cycle", 64'(done_cyc), 64'd10);
    checkOutput("7_8_strobe_seq", seq, 64'h120202020);
    checkOutput("7_8_hab_pulses", 64'(n_hab), 64'd0);
    checkOutput("7_8_quotient", 64'(q_at_done), 64'd0);
    checkOutput("7_8_remainder", 64'(a_at_done), 64'd7);
    @(negedge clk);

    $display("[TB] divide by zero");
    applyStimulus(4'd9, 4'd0, 1'b0);
    checkOutput("dz_done_cycle", 64'(done_cyc), 64'd1);
    checkOutput("dz_erro", 64'(erro_at_done), 64'd1);
    checkOutput("dz_no_strobes", 64'(n_load + n_shift + n_hab + n_setq), 64'd0);
    @(negedge clk);
    checkOutput("dz_erro_persists", {erro, busy, done}, 64'b100);

    $display("[TB] 6 / 2 after error");
    applyStimulus(4'd6, 4'd2, 1'b0);
    checkOutput("6_2_done_cycle", 64'(done_cyc), 64'd12);
    checkOutput("6_2_erro_cleared", 64'(erro_at_done), 64'd0);
    checkOutput("6_2_quotient", 64'(q_at_done), 64'd3);
    checkOutput("6_2_remainder", 64'(a_at_done), 64'd0);
    @(negedge clk);

    $display("[TB] 13 / 3 with start held");
    applyStimulus(4'd13, 4'd3, 1'b1);
    checkOutput("hold_done_cycle", 64'(done_cyc), 64'd11);
    checkOutput("hold_single_load", 64'(n_load), 64'd1);
    checkOutput("hold_busy_in_done", 64'(busy_at_done), 64'd0);
    checkOutput("hold_quotient", 64'(q_at_done), 64'd4);
    @(negedge clk);
    checkOutput("hold_idle_after", {busy, load, done}, 64'd0);
    @(negedge clk);
    checkOutput("hold_no_restart", {busy, load}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
